// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its write buffer.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package dmem_pkg;
  localparam int DM_W   = `WORD_WIDTH;
  localparam int DM_AW  = 10;
  // Word index lives in byte-address bits [IDX_HI:IDX_LO]
  localparam int IDX_LO = 2;
  localparam int IDX_HI = DM_AW + 1;

  typedef struct packed {
    logic             valid;
    logic [DM_AW-1:0] addr;
    logic [DM_W-1:0]  data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);
endpackage

// File: rtl/dmem_write_buf.sv
// Coalescing store FIFO: match/coalesce on write, enqueue at tail, dequeue at head,
// and an associative forward-read port for loads.
module dmem_write_buf
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DM_AW-1:0] wr_addr,
  input  logic [DM_W-1:0]  wr_data,
  input  logic             deq,
  input  logic [DM_AW-1:0] rd_addr,
  output logic             wr_hit,
  output logic             wr_hit_head,
  output logic             full,
  output logic             empty,
  output wb_entry_t        head,
  output logic             rd_hit,
  output logic [DM_W-1:0]  rd_data
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t     ent [DEPTH];
  logic [PW-1:0] hd, tl, wr_idx;
  logic [PW:0]   cnt;
  logic          do_deq, do_enq;

  // Coalescing guarantees at most one valid entry per word address
  always_comb begin
    wr_hit  = 1'b0;
    wr_idx  = '0;
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent[i].valid && ent[i].addr == wr_addr) begin
        wr_hit = 1'b1;
        wr_idx = PW'(i);
      end
      if (ent[i].valid && ent[i].addr == rd_addr) begin
        rd_hit  = 1'b1;
        rd_data = ent[i].data;
      end
    end
  end

  assign wr_hit_head = wr_hit && (wr_idx == hd);
  assign full        = (cnt == (PW+1)'(DEPTH));
  assign empty       = (cnt == '0);
  assign head        = ent[hd];
  assign do_deq      = deq && !empty;
  assign do_enq      = wr_en && !wr_hit && (!full || do_deq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (do_deq) begin
        ent[hd].valid <= 1'b0;
        hd            <= hd + 1'b1;
      end
      if (wr_en && wr_hit) ent[wr_idx].data <= wr_data;
      // When full, tail aliases head: enqueue overrides the dequeue clear above
      if (do_enq) begin
        ent[tl] <= '{valid: 1'b1, addr: wr_addr, data: wr_data};
        tl      <= tl + 1'b1;
      end
      cnt <= cnt + (PW+1)'(do_enq) - (PW+1)'(do_deq);
    end
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: 1-cycle loads with store forwarding, stores drained via write buffer.
// Optional DMEM_STATS_EN adds forward/coalesce event counters.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int W       = DM_W,
  parameter int DEPTH   = 4,
  parameter int SRAM_AW = DM_AW
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [W-1:0]       l_addr,
  output logic [W-1:0]       l_data,
  input  logic               store_en,
  input  logic [W-1:0]       s_addr,
  input  logic [W-1:0]       s_data,
  output logic               sram_en,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [W-1:0]       sram_wdata,
  input  logic [W-1:0]       sram_rdata,
  output logic               wb_empty,
  output logic               proto_err
`ifdef DMEM_STATS_EN
  ,
  output logic [W-1:0]       stat_fwd,
  output logic [W-1:0]       stat_coal
`endif
);
  logic [SRAM_AW-1:0] l_idx, s_idx;
  wb_entry_t          head;
  logic               wr_hit, wr_hit_head, full, empty, rd_hit;
  logic [W-1:0]       rd_data;
  logic               coal_head, deq, drop;
  logic               load_q, fwd_hit_q;
  logic [W-1:0]       fwd_q, hold_q, ret;
  logic               unused_bits;

  assign l_idx = l_addr[IDX_HI:IDX_LO];
  assign s_idx = s_addr[IDX_HI:IDX_LO];
  assign unused_bits = ^{l_addr[1:0], l_addr[W-1:IDX_HI+1],
                         s_addr[1:0], s_addr[W-1:IDX_HI+1], head.valid};

  dmem_write_buf #(.DEPTH(DEPTH)) u_wb (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (store_en),
    .wr_addr     (s_idx),
    .wr_data     (s_data),
    .deq         (deq),
    .rd_addr     (l_idx),
    .wr_hit      (wr_hit),
    .wr_hit_head (wr_hit_head),
    .full        (full),
    .empty       (empty),
    .head        (head),
    .rd_hit      (rd_hit),
    .rd_data     (rd_data)
  );

  // A store landing on the draining head keeps the entry; SRAM gets the newest data now
  assign coal_head = store_en && wr_hit_head;
  assign deq       = !load_en && !empty && !coal_head;
  assign drop      = store_en && !wr_hit && full && !deq;
  assign wb_empty  = empty;

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!rst) begin
      if (load_en) begin
        sram_en   = 1'b1;
        sram_addr = l_idx;
      end else if (!empty) begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = head.addr;
        sram_wdata = coal_head ? s_data : head.data;
      end
    end
  end

  assign ret    = fwd_hit_q ? fwd_q : sram_rdata;
  assign l_data = load_q ? ret : hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q    <= 1'b0;
      fwd_hit_q <= 1'b0;
      fwd_q     <= '0;
      hold_q    <= '0;
      proto_err <= 1'b0;
    end else begin
      load_q <= load_en;
      if (load_en) begin
        fwd_hit_q <= rd_hit;
        fwd_q     <= rd_data;
      end
      if (load_q) hold_q <= ret;
      if (drop) proto_err <= 1'b1;
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fwd  <= '0;
      stat_coal <= '0;
    end else begin
      if (load_en && rd_hit) stat_fwd <= stat_fwd + 1'b1;
      if (store_en && wr_hit) stat_coal <= stat_coal + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic
// checked against an architectural memory model.
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0, store_en = 1'b0;
  logic [31:0] l_addr = '0, s_addr = '0, s_data = '0;
  logic [31:0] l_data;
  logic        sram_en, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        wb_empty, proto_err;
`ifdef DMEM_STATS_EN
  logic [31:0] stat_fwd, stat_coal;
`endif

  int n_chk = 0, n_pass = 0;
  int exp_fwd = 0, exp_coal = 0;

  // SRAM environment with a backdoor write port and a write log
  logic [31:0] mem [1024];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  logic [9:0]  wq_a [$];
  logic [31:0] wq_d [$];

  dmem_ctrl dut (
    .clk(clk), .rst(rst), .load_en(load_en), .l_addr(l_addr), .l_data(l_data),
    .store_en(store_en), .s_addr(s_addr), .s_data(s_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .wb_empty(wb_empty), .proto_err(proto_err)
`ifdef DMEM_STATS_EN
    , .stat_fwd(stat_fwd), .stat_coal(stat_coal)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (sram_en && sram_we) begin
      mem[sram_addr] <= sram_wdata;
      wq_a.push_back(sram_addr);
      wq_d.push_back(sram_wdata);
    end else if (sram_en) sram_rdata <= mem[sram_addr];
  end

  task automatic drive(input bit ld, input logic [31:0] la, input bit st,
                       input logic [31:0] sa, input logic [31:0] sd);
    load_en = ld; l_addr = la; store_en = st; s_addr = sa; s_data = sd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic test_reset;
    load_en = 1'b1; l_addr = 32'h40;
    @(negedge clk);
    n_chk++; if (wb_empty !== 1'b1) $display("FAIL reset_wb_empty got=%b exp=1", wb_empty); else n_pass++;
    n_chk++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err got=%b exp=0", proto_err); else n_pass++;
    n_chk++; if (l_data !== 32'h0) $display("FAIL reset_l_data got=%h exp=0", l_data); else n_pass++;
    n_chk++; if (sram_en !== 1'b0) $display("FAIL reset_sram_en got=%b exp=0", sram_en); else n_pass++;
    n_chk++; if (sram_we !== 1'b0) $display("FAIL reset_sram_we got=%b exp=0", sram_we); else n_pass++;
    n_chk++; if (sram_addr !== 10'h0) $display("FAIL reset_sram_addr got=%h exp=0", sram_addr); else n_pass++;
    n_chk++; if (sram_wdata !== 32'h0) $display("FAIL reset_sram_wdata got=%h exp=0", sram_wdata); else n_pass++;
    load_en = 1'b0; l_addr = '0;
    bd_write(10'h10, 32'hDEADBEEF);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load;
    drive(1, 32'h40, 0, 0, 0);
    n_chk++; if (l_data !== 32'hDEADBEEF) $display("FAIL load_data got=%h exp=deadbeef", l_data); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h40, 0, 0, 0);
      n_chk++; if (l_data !== 32'hDEADBEEF) $display("FAIL load_hold got=%h exp=deadbeef", l_data); else n_pass++;
    end
  endtask

  task automatic test_forward;
    int n0;
    n0 = wq_a.size();
    drive(0, 0, 1, 32'h40, 32'h11111111);
    drive(1, 32'h40, 0, 0, 0);
    n_chk++; if (l_data !== 32'h11111111) $display("FAIL fwd_data got=%h exp=11111111", l_data); else n_pass++;
    exp_fwd++;
    idle(3);
    n_chk++; if (mem[10'h10] !== 32'h11111111) $display("FAIL fwd_sram got=%h exp=11111111", mem[10'h10]); else n_pass++;
    n_chk++; if (wq_a.size() != n0 + 1) $display("FAIL fwd_wcount got=%0d exp=%0d", wq_a.size() - n0, 1); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = wq_a.size();
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'(i * 4), 32'hA000_0000 + 32'(i));
    idle(5);
    n_chk++; if (wq_a.size() != n0 + 4) $display("FAIL b2b_wcount got=%0d exp=4", wq_a.size() - n0); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (wq_a.size() > n0 + i) begin
        n_chk++;
        if (wq_a[n0+i] !== 10'(i) || wq_d[n0+i] !== 32'hA000_0000 + 32'(i))
          $display("FAIL b2b_order[%0d] got=%h/%h exp=%h/%h", i, wq_a[n0+i], wq_d[n0+i], i, 32'hA000_0000 + 32'(i));
        else n_pass++;
      end
    end
    n_chk++; if (wb_empty !== 1'b1) $display("FAIL b2b_wb_empty got=%b exp=1", wb_empty); else n_pass++;
    n_chk++; if (proto_err !== 1'b0) $display("FAIL b2b_proto_err got=%b exp=0", proto_err); else n_pass++;
  endtask

  task automatic test_coalesce;
    drive(0, 0, 1, 32'h8, 32'h1);
    drive(0, 0, 1, 32'h8, 32'h2);
    exp_coal++;
    idle(4);
    n_chk++; if (mem[2] !== 32'h2) $display("FAIL coal_sram got=%h exp=2", mem[2]); else n_pass++;
    n_chk++; if (wq_d[$] !== 32'h2) $display("FAIL coal_last_write got=%h exp=2", wq_d[$]); else n_pass++;
    n_chk++; if (wb_empty !== 1'b1) $display("FAIL coal_wb_empty got=%b exp=1", wb_empty); else n_pass++;
`ifdef DMEM_STATS_EN
    n_chk++; if (stat_coal !== 32'(exp_coal)) $display("FAIL coal_stat got=%0d exp=%0d", stat_coal, exp_coal); else n_pass++;
    n_chk++; if (stat_fwd !== 32'(exp_fwd)) $display("FAIL fwd_stat got=%0d exp=%0d", stat_fwd, exp_fwd); else n_pass++;
`endif
  endtask

  task automatic test_proto_err;
    bd_write(10'h24, 32'h0);
    for (int i = 0; i < 4; i++) drive(1, 32'h400, 1, 32'h80 + 32'(i * 4), 32'hC000_0000 + 32'(i));
    n_chk++; if (proto_err !== 1'b0) $display("FAIL proto_before got=%b exp=0", proto_err); else n_pass++;
    n_chk++; if (wb_empty !== 1'b0) $display("FAIL proto_full_wb_empty got=%b exp=0", wb_empty); else n_pass++;
    drive(1, 32'h400, 1, 32'h90, 32'hBAD0BAD0);
    n_chk++; if (proto_err !== 1'b1) $display("FAIL proto_set got=%b exp=1", proto_err); else n_pass++;
    idle(6);
    n_chk++; if (proto_err !== 1'b1) $display("FAIL proto_sticky got=%b exp=1", proto_err); else n_pass++;
    n_chk++; if (mem[10'h24] !== 32'h0) $display("FAIL proto_dropped got=%h exp=0", mem[10'h24]); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (mem[10'h20 + 10'(i)] !== 32'hC000_0000 + 32'(i))
        $display("FAIL proto_drain[%0d] got=%h exp=%h", i, mem[10'h20 + 10'(i)], 32'hC000_0000 + 32'(i));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    for (int i = 0; i < 3; i++) drive(1, 32'h400, 1, 32'h100 + 32'(i * 4), 32'h5555_0000 + 32'(i));
    n0 = wq_a.size();
    load_en = 1'b0; store_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (wb_empty !== 1'b1) $display("FAIL rstmid_wb_empty got=%b exp=1", wb_empty); else n_pass++;
    n_chk++; if (sram_en !== 1'b0) $display("FAIL rstmid_sram_en got=%b exp=0", sram_en); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(4);
    n_chk++; if (wq_a.size() != n0) $display("FAIL rstmid_writes got=%0d exp=0", wq_a.size() - n0); else n_pass++;
    n_chk++; if (proto_err !== 1'b0) $display("FAIL rstmid_proto_err got=%b exp=0", proto_err); else n_pass++;
    n_chk++; if (sram_en !== 1'b0) $display("FAIL rstmid_idle_sram_en got=%b exp=0", sram_en); else n_pass++;
    exp_fwd = 0;
    exp_coal = 0;
  endtask

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Architectural model: a load returns the latest store to its word in program order;
  // pending-address queue tracks which stores are still buffered.
  task automatic test_random;
    logic [31:0] refm [8];
    logic [31:0] exp_l, la, sa, d;
    int q[$];
    int r, li, si;
    bit ld, st, hit, have_l;
    have_l = 1'b0;
    exp_l = '0;
    for (int i = 0; i < 8; i++) begin
      refm[i] = $urandom;
      bd_write(10'(i), refm[i]);
    end
    for (int c = 0; c < 400; c++) begin
      r  = $urandom_range(0, 2);
      li = $urandom_range(0, 7);
      si = $urandom_range(0, 7);
      la = ($urandom & 32'hFFFF_F003) | (32'(li) << 2);
      sa = ($urandom & 32'hFFFF_F003) | (32'(si) << 2);
      d  = $urandom;
      ld = (r == 0);
      st = (r == 1);
      if (ld) begin
        exp_l = refm[li];
        have_l = 1'b1;
        if (in_q(q, li)) exp_fwd++;
      end else if (st) begin
        hit = in_q(q, si);
        if (hit) begin
          exp_coal++;
          if (q[0] != si) void'(q.pop_front());
        end else begin
          if (q.size() > 0) void'(q.pop_front());
          q.push_back(si);
        end
        refm[si] = d;
      end else if (q.size() > 0) void'(q.pop_front());
      drive(ld, la, st, sa, d);
      if (have_l) begin
        n_chk++; if (l_data !== exp_l) $display("FAIL rand_l_data cyc=%0d got=%h exp=%h", c, l_data, exp_l); else n_pass++;
      end
      n_chk++;
      if (wb_empty !== (q.size() == 0)) $display("FAIL rand_wb_empty cyc=%0d got=%b exp=%b", c, wb_empty, q.size() == 0);
      else n_pass++;
    end
    idle(6);
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (mem[i] !== refm[i]) $display("FAIL rand_sram[%0d] got=%h exp=%h", i, mem[i], refm[i]); else n_pass++;
    end
    n_chk++; if (proto_err !== 1'b0) $display("FAIL rand_proto_err got=%b exp=0", proto_err); else n_pass++;
`ifdef DMEM_STATS_EN
    n_chk++; if (stat_fwd !== 32'(exp_fwd)) $display("FAIL rand_stat_fwd got=%0d exp=%0d", stat_fwd, exp_fwd); else n_pass++;
    n_chk++; if (stat_coal !== 32'(exp_coal)) $display("FAIL rand_stat_coal got=%0d exp=%0d", stat_coal, exp_coal); else n_pass++;
`endif
  endtask

  initial begin
    test_reset;
    test_load;
    test_forward;
    test_back_to_back;
    test_coalesce;
    test_proto_err;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
